// File: rtl/vga_timing_scaler.sv
// VGA timing generator and integer-scaled frame-buffer reader with latency-matched sync/enable.
// Defining VGA_TEST_PATTERN_EN adds a test_mode input that overrides RGB with 8 vertical colour bars.
module vga_timing_scaler #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int SCALE      = 1,
    parameter int COLOR_BITS = 4,
    parameter int RD_LATENCY = 1,
    localparam int AW = $clog2((WIDTH / SCALE) * (HEIGHT / SCALE)),
    localparam int XW = $clog2(WIDTH) + 1,
    localparam int YW = $clog2(HEIGHT) + 1
) (
    input  logic                    pclk,
    input  logic                    rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                    test_mode,
`endif
    output logic [AW-1:0]           r_addr,
    output logic                    r_en,
    input  logic [3*COLOR_BITS-1:0] r_data,
    output logic [COLOR_BITS-1:0]   red_bits,
    output logic [COLOR_BITS-1:0]   green_bits,
    output logic [COLOR_BITS-1:0]   blue_bits,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic [XW-1:0]           pixel_x,
    output logic [YW-1:0]           pixel_y,
    output logic                    frame_start
);

    localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int SW      = WIDTH / SCALE;
    localparam int SH      = HEIGHT / SCALE;
    localparam int SUBW    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int SXW     = $clog2(SW) + 1;
    localparam int SYW     = $clog2(SH) + 1;
    localparam int DEPTH   = RD_LATENCY + 1;
    localparam logic HS_LVL = 1'(HS_POL);
    localparam logic VS_LVL = 1'(VS_POL);

    typedef struct packed {
        logic          act;
        logic          hs;
        logic          vs;
        logic          fm;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } stage_t;

    logic [HCW-1:0]  r_h_cnt;
    logic [VCW-1:0]  r_v_cnt;
    logic [SUBW-1:0] r_sx_sub;
    logic [SUBW-1:0] r_sy_sub;
    logic [SXW-1:0]  r_sx;
    logic [SYW-1:0]  r_sy;
    logic [AW-1:0]   r_row_base;
    stage_t          r_pipe [DEPTH];

    logic            w_h_last;
    logic            w_v_last;
    logic            w_line_end;
    logic [AW-1:0]   w_addr;
    stage_t          w_s0;
    stage_t          w_tail;
    logic [3*COLOR_BITS-1:0] w_rgb;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]      w_bar;
`endif

    assign w_h_last   = (r_h_cnt == HCW'(H_TOTAL - 1));
    assign w_v_last   = (r_v_cnt == VCW'(V_TOTAL - 1));
    assign w_line_end = w_s0.act && (r_h_cnt == HCW'(WIDTH - 1));
    assign w_addr     = r_row_base + AW'(r_sx);
    assign w_tail     = r_pipe[DEPTH-1];

    always_comb begin
        w_s0     = '0;
        w_s0.act = (r_h_cnt < HCW'(WIDTH)) && (r_v_cnt < VCW'(HEIGHT));
        w_s0.hs  = (r_h_cnt >= HCW'(WIDTH + H_FP)) && (r_h_cnt <= HCW'(WIDTH + H_FP + H_SYNC - 1));
        w_s0.vs  = (r_v_cnt >= VCW'(HEIGHT + V_FP)) && (r_v_cnt <= VCW'(HEIGHT + V_FP + V_SYNC - 1));
        w_s0.fm  = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_s0.x   = w_s0.act ? XW'(r_h_cnt) : '0;
        w_s0.y   = w_s0.act ? YW'(r_v_cnt) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Source position tracks display position by counting replications instead of dividing.
    always_ff @(posedge pclk) begin
        if (rst || (w_h_last && w_v_last)) begin
            r_sx_sub   <= '0;
            r_sx       <= '0;
            r_sy_sub   <= '0;
            r_sy       <= '0;
            r_row_base <= '0;
        end else if (w_line_end) begin
            r_sx_sub <= '0;
            r_sx     <= '0;
            if (r_sy_sub == SUBW'(SCALE - 1)) begin
                r_sy_sub   <= '0;
                r_sy       <= r_sy + 1'b1;
                r_row_base <= r_row_base + AW'(SW);
            end else begin
                r_sy_sub <= r_sy_sub + 1'b1;
            end
        end else if (w_s0.act) begin
            if (r_sx_sub == SUBW'(SCALE - 1)) begin
                r_sx_sub <= '0;
                r_sx     <= r_sx + 1'b1;
            end else begin
                r_sx_sub <= r_sx_sub + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_en   <= 1'b0;
            r_addr <= '0;
        end else begin
            r_en <= w_s0.act;
            if (w_s0.act) begin
                r_addr <= w_addr;
            end
        end
    end

    // NOTE: this delay line is control state, not storage, so it is reset to flush stale enables.
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_s0;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_comb begin
        w_rgb = r_data;
`ifdef VGA_TEST_PATTERN_EN
        w_bar = 3'(w_tail.x / XW'(WIDTH / 8));
        if (test_mode) begin
            w_rgb = {{COLOR_BITS{w_bar[2]}}, {COLOR_BITS{w_bar[1]}}, {COLOR_BITS{w_bar[0]}}};
        end
`endif
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            de          <= 1'b0;
            red_bits    <= '0;
            green_bits  <= '0;
            blue_bits   <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            hsync       <= ~HS_LVL;
            vsync       <= ~VS_LVL;
        end else begin
            de          <= w_tail.act;
            {red_bits, green_bits, blue_bits} <= w_tail.act ? w_rgb : '0;
            pixel_x     <= w_tail.x;
            pixel_y     <= w_tail.y;
            frame_start <= w_tail.fm;
            hsync       <= ~(w_tail.hs ^ HS_LVL);
            vsync       <= ~(w_tail.vs ^ VS_LVL);
        end
    end

endmodule
